// File: rtl/sram_burst_ctrl.sv
// Burst controller for a 16-bit asynchronous SRAM: one request moves BEATS halfwords with registered strobes.
// Optional macro SRAM_BYTE_MASK_EN adds a per-byte write mask input req_be.
module sram_burst_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int BEATS    = 2,
    parameter int WAIT_CYC = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [16*BEATS-1:0]   req_wdata,
`ifdef SRAM_BYTE_MASK_EN
    input  logic [2*BEATS-1:0]    req_be,
`endif
    output logic                  rsp_valid,
    output logic [16*BEATS-1:0]   rsp_rdata,
    output logic [22:0]           sram_addr,
    inout  wire  [15:0]           sram_dq,
    output logic                  sram_ce_n,
    output logic                  sram_we_n,
    output logic                  sram_oe_n,
    output logic                  sram_ub_n,
    output logic                  sram_lb_n,
    output logic                  busy
);
    localparam int DW = 16 * BEATS;
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYC - 1);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RECOVER, DONE} state_t;

    state_t              state_q, state_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [WW-1:0]       wait_q, wait_d;

    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DW-1:0]       wdata_q;
    logic [DW-1:0]       rdata_q;

    logic                accept;
    logic                we_nx;
    logic [ADDR_W-1:0]   base_nx;
    logic [DW-1:0]       wdata_nx;

    logic [22:0]         sram_addr_q, sram_addr_d;
    logic                ce_n_q, ce_n_d;
    logic                we_n_q, we_n_d;
    logic                oe_n_q, oe_n_d;
    logic                ub_n_q, ub_n_d;
    logic                lb_n_q, lb_n_d;
    logic                dq_oe_q, dq_oe_d;
    logic [15:0]         dq_out_q, dq_out_d;
    logic                rsp_valid_q, rsp_valid_d;

`ifdef SRAM_BYTE_MASK_EN
    logic [2*BEATS-1:0]  be_q;
    logic [2*BEATS-1:0]  be_nx;

    // Beat 0 takes the top mask pair, matching the MS-first halfword order.
    function automatic logic [1:0] beat_be(input logic [2*BEATS-1:0] be, input logic [BW-1:0] k);
        return be[2*(BEATS-1-int'(k)) +: 2];
    endfunction
`endif

    function automatic logic [15:0] beat_hw(input logic [DW-1:0] w, input logic [BW-1:0] k);
        return w[16*(BEATS-1-int'(k)) +: 16];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = SETUP;
                    beat_d  = '0;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                wait_d  = '0;
            end
            ACCESS: begin
                if (wait_q == WAIT_LAST) state_d = RECOVER;
                else                     wait_d  = wait_q + 1'b1;
            end
            RECOVER: begin
                if (beat_q == BEAT_LAST) begin
                    state_d = DONE;
                end else begin
                    state_d = SETUP;
                    beat_d  = beat_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every strobe leaves a flop.
    always_comb begin
        accept   = (state_q == IDLE) && req_valid;
        we_nx    = accept ? req_we    : we_q;
        base_nx  = accept ? req_addr  : addr_q;
        wdata_nx = accept ? req_wdata : wdata_q;
`ifdef SRAM_BYTE_MASK_EN
        be_nx    = accept ? req_be    : be_q;
`endif
        sram_addr_d = sram_addr_q;
        ce_n_d      = 1'b1;
        we_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        ub_n_d      = 1'b1;
        lb_n_d      = 1'b1;
        dq_oe_d     = 1'b0;
        dq_out_d    = dq_out_q;
        rsp_valid_d = 1'b0;
        case (state_d)
            SETUP: begin
                ce_n_d      = 1'b0;
                sram_addr_d = 23'(ADDR_W'(base_nx + ADDR_W'(beat_d)));
                dq_oe_d     = we_nx;
                dq_out_d    = beat_hw(wdata_nx, beat_d);
            end
            ACCESS: begin
                ce_n_d  = 1'b0;
                we_n_d  = ~we_nx;
                oe_n_d  = we_nx;
                dq_oe_d = we_nx;
                ub_n_d  = 1'b0;
                lb_n_d  = 1'b0;
`ifdef SRAM_BYTE_MASK_EN
                if (we_nx) {ub_n_d, lb_n_d} = ~beat_be(be_nx, beat_d);
`endif
            end
            RECOVER: dq_oe_d     = we_nx;
            DONE:    rsp_valid_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
`ifdef SRAM_BYTE_MASK_EN
            be_q    <= req_be;
`endif
        end
        dq_out_q <= dq_out_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sram_addr_q <= '0;
            ce_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            sram_addr_q <= sram_addr_d;
            ce_n_q      <= ce_n_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
            ub_n_q      <= ub_n_d;
            lb_n_q      <= lb_n_d;
            dq_oe_q     <= dq_oe_d;
            rsp_valid_q <= rsp_valid_d;
            // Sample on the last strobe cycle, when the SRAM output has settled longest.
            if (state_q == ACCESS && wait_q == WAIT_LAST && !we_q)
                rdata_q[16*(BEATS-1-int'(beat_q)) +: 16] <= sram_dq;
        end
    end

    assign sram_dq   = dq_oe_q ? dq_out_q : 16'hzzzz;
    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign sram_addr = sram_addr_q;
    assign sram_ce_n = ce_n_q;
    assign sram_we_n = we_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_ub_n = ub_n_q;
    assign sram_lb_n = lb_n_q;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Directed bench for sram_burst_ctrl: default instance with an SRAM model plus a BEATS=4/WAIT_CYC=1 read-only instance.
// Define SRAM_BYTE_MASK_EN to also exercise the byte-mask port.
module tb_sram_burst_ctrl;
`ifdef SRAM_BYTE_MASK_EN
    localparam bit BYTE_MASK = 1'b1;
`else
    localparam bit BYTE_MASK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_we;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    wire         req_ready, rsp_valid, busy;
    wire  [31:0] rsp_rdata;
    wire  [22:0] sram_addr;
    tri1  [15:0] sram_dq;
    wire         sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n;

    logic        b_req_valid;
    logic [15:0] b_req_addr;
    logic [63:0] b_req_wdata;
    logic [7:0]  b_req_be;
    wire         b_req_ready, b_rsp_valid, b_busy;
    wire  [63:0] b_rsp_rdata;
    wire  [22:0] b_sram_addr;
    tri1  [15:0] b_sram_dq;
    wire         b_ce_n, b_we_n, b_oe_n, b_ub_n, b_lb_n;

    sram_burst_ctrl #(.ADDR_W(16), .BEATS(2), .WAIT_CYC(3)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef SRAM_BYTE_MASK_EN
        .req_be(req_be),
`endif
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .sram_addr(sram_addr),
        .sram_dq(sram_dq), .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n),
        .sram_oe_n(sram_oe_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n), .busy(busy)
    );

    sram_burst_ctrl #(.ADDR_W(16), .BEATS(4), .WAIT_CYC(1)) dut_b4 (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_we(1'b0), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
`ifdef SRAM_BYTE_MASK_EN
        .req_be(b_req_be),
`endif
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .sram_addr(b_sram_addr),
        .sram_dq(b_sram_dq), .sram_ce_n(b_ce_n), .sram_we_n(b_we_n),
        .sram_oe_n(b_oe_n), .sram_ub_n(b_ub_n), .sram_lb_n(b_lb_n), .busy(b_busy)
    );

    // SRAM model for the default instance: byte-laned writes, combinational reads.
    logic [15:0] mem [0:65535];
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_ub_n) mem[sram_addr[15:0]][15:8] <= sram_dq[15:8];
            if (!sram_lb_n) mem[sram_addr[15:0]][7:0]  <= sram_dq[7:0];
        end
    end
    assign sram_dq   = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[15:0]] : 16'hzzzz;
    assign b_sram_dq = (!b_ce_n && !b_oe_n && !b_ub_n && !b_lb_n) ? (b_sram_addr[15:0] ^ 16'h5A5A) : 16'hzzzz;

    int overlap = 0;
    always @(negedge clk) begin
        if (!sram_we_n && !sram_oe_n) overlap++;
        if (!b_we_n && !b_oe_n) overlap++;
    end

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] sb [$];
    logic [31:0] last_rd;
    logic [15:0] exp_mem [0:65535];
    logic [4:0]  tr_s [0:15];
    logic [22:0] tr_a [0:15];
    logic [15:0] tr_d [0:15];
    int          rv_cyc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int count_low(input int b, input int s, input int e);
        int n = 0;
        for (int i = s; i <= e; i++) if (tr_s[i][b] == 1'b0) n++;
        return n;
    endfunction

    task automatic run_txn(input logic we, input logic [15:0] a, input logic [31:0] wd, input logic [3:0] be);
        logic [15:0] a1;
        logic [3:0]  m;
        logic [31:0] e;
        a1 = a + 16'd1;
        m  = BYTE_MASK ? be : 4'hF;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
        if (we) begin
            if (m[3]) exp_mem[a][15:8]  = wd[31:24];
            if (m[2]) exp_mem[a][7:0]   = wd[23:16];
            if (m[1]) exp_mem[a1][15:8] = wd[15:8];
            if (m[0]) exp_mem[a1][7:0]  = wd[7:0];
        end else begin
            last_rd = {exp_mem[a], exp_mem[a1]};
        end
        sb.push_back(last_rd);
        chk("ready_before_req", {63'd0, req_ready}, 64'd1);
        step();
        req_valid = 1'b0;
        rv_cyc = -1;
        for (int c = 1; c <= 12; c++) begin
            tr_s[c] = {sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n};
            tr_a[c] = sram_addr;
            tr_d[c] = sram_dq;
            if (rsp_valid) begin
                if (rv_cyc < 0) rv_cyc = c;
                chk("sb_nonempty", {63'd0, sb.size() > 0}, 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e});
                end
            end
            step();
        end
        chk("rsp_latency", 64'(rv_cyc), 64'd11);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2, npulse;
        logic [63:0] b_exp;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = 4'hF;
        b_req_valid = 1'b0; b_req_addr = 16'h0010; b_req_wdata = '0; b_req_be = 8'hFF;
        last_rd = '0;
        step(); step(); step();
        rst = 1'b0;

        // Reset values
        chk("rst_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_rdata", {32'd0, rsp_rdata}, 64'd0);
        chk("rst_addr", {41'd0, sram_addr}, 64'd0);
        chk("rst_strobes", {59'd0, sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n}, 64'h1F);
        chk("rst_dq_z", {48'd0, sram_dq}, 64'hFFFF);

        // Write 0xDEADBEEF at 0x1234
        run_txn(1'b1, 16'h1234, 32'hDEADBEEF, 4'hF);
        chk("wr_setup_addr", {41'd0, tr_a[1]}, 64'h1234);
        chk("wr_setup_strobes", {61'd0, tr_s[1][4:2]}, 64'b011);
        chk("wr_setup_dq", {48'd0, tr_d[1]}, 64'hDEAD);
        chk("wr_recover_dq", {48'd0, tr_d[5]}, 64'hDEAD);
        chk("wr_recover_strobes", {59'd0, tr_s[5]}, 64'h1F);
        chk("wr_beat1_addr", {41'd0, tr_a[6]}, 64'h1235);
        chk("wr_beat1_dq", {48'd0, tr_d[6]}, 64'hBEEF);
        chk("wr_done_dq_z", {48'd0, tr_d[11]}, 64'hFFFF);
        chk("wr_we_low_b0", 64'(count_low(3, 1, 5)), 64'd3);
        chk("wr_we_low_b1", 64'(count_low(3, 6, 10)), 64'd3);
        chk("wr_oe_low", 64'(count_low(2, 1, 12)), 64'd0);
        chk("wr_ub_low_b0", 64'(count_low(1, 1, 5)), 64'd3);
        chk("wr_lb_low_b1", 64'(count_low(0, 6, 10)), 64'd3);
        chk("wr_mem_hi", {48'd0, mem[16'h1234]}, 64'hDEAD);
        chk("wr_mem_lo", {48'd0, mem[16'h1235]}, 64'hBEEF);

        // Read back 0x1234
        run_txn(1'b0, 16'h1234, 32'h0, 4'hF);
        chk("rd_oe_low_b0", 64'(count_low(2, 1, 5)), 64'd3);
        chk("rd_oe_low_b1", 64'(count_low(2, 6, 10)), 64'd3);
        chk("rd_we_low", 64'(count_low(3, 1, 12)), 64'd0);
        chk("rd_setup_dq_z", {48'd0, tr_d[1]}, 64'hFFFF);
        chk("rd_recover_dq_z", {48'd0, tr_d[5]}, 64'hFFFF);
        chk("rd_access_dq", {48'd0, tr_d[4]}, 64'hDEAD);
        chk("rd_setup1_dq_z", {48'd0, tr_d[6]}, 64'hFFFF);

        // Address wrap at 0xFFFF; rsp_rdata must hold across this write
        run_txn(1'b1, 16'hFFFF, 32'hCAFEF00D, 4'hF);
        chk("wrap_addr_b0", {41'd0, tr_a[1]}, 64'h0FFFF);
        chk("wrap_addr_b1", {41'd0, tr_a[6]}, 64'h0);
        run_txn(1'b0, 16'hFFFF, 32'h0, 4'hF);

`ifdef SRAM_BYTE_MASK_EN
        run_txn(1'b1, 16'h0200, 32'hAAAABBBB, 4'hF);
        run_txn(1'b1, 16'h0200, 32'h11223344, 4'b1001);
        chk("be_ub_low_b0", 64'(count_low(1, 2, 4)), 64'd3);
        chk("be_lb_low_b0", 64'(count_low(0, 2, 4)), 64'd0);
        chk("be_ub_low_b1", 64'(count_low(1, 7, 9)), 64'd0);
        chk("be_lb_low_b1", 64'(count_low(0, 7, 9)), 64'd3);
        chk("be_masked_we_b1", 64'(count_low(3, 6, 10)), 64'd3);
        run_txn(1'b0, 16'h0200, 32'h0, 4'hF);
`endif

        // Reset in the middle of write beat 1
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0040; req_wdata = 32'h12345678; req_be = 4'hF;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("abort_pre_we", {63'd0, sram_we_n}, 64'd0);
        chk("abort_pre_addr", {41'd0, sram_addr}, 64'h41);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_strobes", {59'd0, sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n}, 64'h1F);
        chk("abort_dq_z", {48'd0, sram_dq}, 64'hFFFF);
        chk("abort_rdata", {32'd0, rsp_rdata}, 64'd0);
        last_rd = '0;
        npulse = 0;
        for (int i = 0; i < 14; i++) begin
            if (rsp_valid) npulse++;
            step();
        end
        chk("abort_no_rsp", 64'(npulse), 64'd0);
        chk("abort_ready", {63'd0, req_ready}, 64'd1);

        // Two reads with req_valid held through busy and DONE
        last_rd = {exp_mem[16'h1234], exp_mem[16'h1235]};
        sb.push_back(last_rd);
        sb.push_back(last_rd);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h1234;
        step();
        t1 = -1; t2 = -1;
        for (int c = 1; c <= 40 && t2 < 0; c++) begin
            if (rsp_valid) begin
                if (t1 < 0) t1 = c;
                else begin t2 = c; req_valid = 1'b0; end
                chk("b2b_sb_nonempty", {63'd0, sb.size() > 0}, 64'd1);
                if (sb.size() > 0) chk("b2b_rdata", {32'd0, rsp_rdata}, {32'd0, sb.pop_front()});
            end
            step();
        end
        req_valid = 1'b0;
        chk("b2b_first", 64'(t1), 64'd11);
        chk("b2b_second", 64'(t2), 64'd23);
        for (int i = 0; i < 3; i++) step();

        // BEATS=4, WAIT_CYC=1 instance, reads back-to-back
        for (int k = 0; k < 4; k++) b_exp[16*(3-k) +: 16] = (b_req_addr + 16'(k)) ^ 16'h5A5A;
        b_req_valid = 1'b1;
        step();
        t1 = -1; t2 = -1;
        for (int c = 1; c <= 60 && t2 < 0; c++) begin
            if (t1 > 0 && c == t1 + 1) chk("b4_idle_gap", {63'd0, b_req_ready}, 64'd1);
            if (t1 > 0 && c == t1 + 2) chk("b4_reaccept", {63'd0, b_busy}, 64'd1);
            if (b_rsp_valid) begin
                if (t1 < 0) t1 = c;
                else begin t2 = c; b_req_valid = 1'b0; end
                chk("b4_rdata", b_rsp_rdata, b_exp);
                chk("b4_addr_pad", {57'd0, b_sram_addr[22:16]}, 64'd0);
            end
            step();
        end
        b_req_valid = 1'b0;
        chk("b4_first", 64'(t1), 64'd13);
        chk("b4_interval", 64'(t2 - t1), 64'd14);

        chk("we_oe_overlap", 64'(overlap), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
